// File: rtl/uart_tx_stream.sv
// Byte-stream to 8N1 UART transmitter, LSB first, with a count of newline frames sent.
// Optional even-parity bit after D7 when UART_TX_PARITY_EN is defined.
module uart_tx_stream #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic [7:0] lines_sent
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_stream: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_stream: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          tx_q, tx_d;
    logic [7:0]    lines_q, lines_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(CLKS_PER_BIT - 1));

    // tx_d is computed for the state being entered so the line is registered
    // and changes exactly on the bit boundary.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        tx_d    = tx_q;
        lines_d = lines_q;
        if (state_q != IDLE) cnt_d = wrap ? '0 : cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    state_d = START;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            START: if (wrap) begin
                state_d = DATA;
                idx_d   = '0;
                tx_d    = data_q[0];
            end
            DATA: if (wrap) begin
                if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
                    tx_d    = ^data_q;
`else
                    state_d = STOP;
                    tx_d    = 1'b1;
                    idx_d   = '0;
`endif
                end else begin
                    idx_d = idx_q + 3'd1;
                    tx_d  = data_q[idx_q + 3'd1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (wrap) begin
                state_d = STOP;
                tx_d    = 1'b1;
                idx_d   = '0;
            end
`endif
            STOP: if (wrap) begin
                if (idx_q == 3'(STOP_BITS - 1)) begin
                    state_d = IDLE;
                    if (data_q == 8'h0A) lines_d = lines_q + 8'd1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            lines_q <= lines_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign tx         = tx_q;
    assign lines_sent = lines_q;
endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream at CLKS_PER_BIT=4, one stop bit.
module tb_uart_tx_stream;
    localparam int CPB = 4;
    localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FB = 1 + 8 + PB + SB;
    localparam int N  = FB * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [7:0] lines_sent;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_lines = 8'd0;

    uart_tx_stream #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx(tx), .busy(busy), .lines_sent(lines_sent)
    );

    always #5 clk = ~clk;

    function automatic logic bitval(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (PB == 1 && j == 9) return ^b;
        return 1'b1;
    endfunction

    // Entered at a negedge with the DUT idle; leaves at the idle negedge after the frame.
    task automatic frame(input string name, input logic [7:0] b, input bit hold_valid, input bit toggle);
        logic [63:0] etx, otx, obusy, ordy, full;
        etx = '0; otx = '0; obusy = '0; ordy = '0;
        full = (64'd1 << N) - 64'd1;
        for (int i = 0; i < N; i++) etx[i] = bitval(b, i / CPB);
        in_data  = b;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_at_start got=%b want=1", name, in_ready);
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            otx[i] = tx; obusy[i] = busy; ordy[i] = in_ready;
            if (!hold_valid) in_valid = 1'b0;
            if (toggle) in_data = 8'(i * 37 + 5);
        end
        if (b == 8'h0A) exp_lines = exp_lines + 8'd1;
        checks++;
        if (otx !== etx) begin
            failures++;
            $display("FAIL %s tx_bits got=%h want=%h", name, otx, etx);
        end
        checks++;
        if (obusy !== full) begin
            failures++;
            $display("FAIL %s busy_span got=%h want=%h", name, obusy, full);
        end
        checks++;
        if (ordy !== 64'd0) begin
            failures++;
            $display("FAIL %s ready_low_span got=%h want=0", name, ordy);
        end
        @(negedge clk);
        checks++;
        if ({tx, busy, in_ready} !== 3'b101) begin
            failures++;
            $display("FAIL %s idle_gap tx/busy/rdy got=%b want=101", name, {tx, busy, in_ready});
        end
        checks++;
        if (lines_sent !== exp_lines) begin
            failures++;
            $display("FAIL %s lines_sent got=%h want=%h", name, lines_sent, exp_lines);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx, busy, in_ready, lines_sent} !== {3'b101, 8'h00}) begin
            failures++;
            $display("FAIL reset_state got=%b want=101_00000000", {tx, busy, in_ready, lines_sent});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        frame("single_68", 8'h68, 1'b0, 1'b0);
        frame("single_0a", 8'h0A, 1'b0, 1'b0);
        frame("single_a5", 8'hA5, 1'b0, 1'b0);
    endtask

    task automatic test_mid_frame_reset;
        in_data = 8'h55; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        exp_lines = 8'd0;
        checks++;
        if ({tx, busy, lines_sent} !== {2'b10, 8'h00}) begin
            failures++;
            $display("FAIL midreset_outputs tx/busy/lines got=%b want=10_00000000", {tx, busy, lines_sent});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, tx} !== 2'b11) begin
            failures++;
            $display("FAIL midreset_release rdy/tx got=%b want=11", {in_ready, tx});
        end
        frame("after_reset_68", 8'h68, 1'b0, 1'b0);
    endtask

    task automatic test_toggle_busy;
        frame("toggle_c3", 8'hC3, 1'b1, 1'b1);
        frame("toggle_next_3c", 8'h3C, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [7:0] msg [13];
        msg = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77,
                8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};
        for (int k = 0; k < 13; k++)
            frame($sformatf("hello_%0d", k), msg[k], (k != 12), 1'b0);
        checks++;
        if (lines_sent !== 8'h01) begin
            failures++;
            $display("FAIL hello_lines got=%h want=01", lines_sent);
        end
    endtask

    task automatic test_wrap;
        for (int k = 0; k < 254; k++) frame("wrap_nl", 8'h0A, (k != 253), 1'b0);
        checks++;
        if (lines_sent !== 8'hFF) begin
            failures++;
            $display("FAIL wrap_255 got=%h want=ff", lines_sent);
        end
        frame("wrap_last", 8'h0A, 1'b0, 1'b0);
        checks++;
        if (lines_sent !== 8'h00) begin
            failures++;
            $display("FAIL wrap_256 got=%h want=00", lines_sent);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_mid_frame_reset;
        test_toggle_busy;
        test_back_to_back;
        test_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
- Downstream consumer of the 8-bit character stream produced by the message generator.
- Accepts one byte per valid/ready handshake and serialises it as an 8N1 UART frame, LSB first, on a single output pin.
- Counts completed newline (8'h0A) bytes so the bench and debugger can track line progress.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range >= 2; baud counter width is $clog2(CLKS_PER_BIT).
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  8  byte to transmit; sampled only on handshake.
- in_valid  input  1  upstream byte available.
- in_ready  output  1  block can accept a byte this cycle.
- tx  output  1  serial line; idle high; registered.
- busy  output  1  high while a frame is in progress (state != IDLE).
- lines_sent  output  8  count of completed 8'h0A frames; wraps.

Behaviour:
- Reset (async assert, any state): tx=1, in_ready=1 once state is IDLE, busy=0, lines_sent=0, bit index=0, baud counter=0, state=IDLE. A frame in flight is discarded; no partial stop bit is emitted.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- in_ready is combinational and equals (state == IDLE).
- Handshake: in_valid && in_ready at rising edge E0 latches in_data into the shift register, and the state goes to START. in_valid without in_ready has no effect; upstream must hold in_data stable until accepted.
- START: tx=0 for exactly CLKS_PER_BIT cycles, starting the cycle after E0.
- DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles. The bit index counts 0..7; after bit 7 the state goes to PARITY if enabled, otherwise STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. The state or bit advances on the wrap.
- Throughput: at least one IDLE cycle between frames, during which tx stays 1. Back-to-back frame period is (1+8+STOP_BITS)*CLKS_PER_BIT + 1 cycles, plus CLKS_PER_BIT when parity is enabled.
- lines_sent increments by 1 on the STOP->IDLE transition when the latched byte equals 8'h0A. It wraps 8'hFF -> 8'h00.
- in_data changes while busy have no effect on the frame in flight.
- CLKS_PER_BIT < 2 or STOP_BITS not in {1,2}: elaboration error via generate-time check.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state follows D7. tx carries the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame is 1+8+1+STOP_BITS bits.
- Undefined: no PARITY state; DATA goes directly to STOP. Frame is 1+8+STOP_BITS bits.

Test Plan:
- Reset: assert rst mid-DATA with CLKS_PER_BIT=4 -> tx=1, busy=0, lines_sent=0 immediately; in_ready=1 after release; next accepted byte is framed from START.
- Single byte 8'h68 ("h"), CLKS_PER_BIT=4 -> tx sequence 0 | 0,0,0,1,0,1,1,0 | 1, each bit 4 cycles. busy high 40 cycles; in_ready low same span.
- Stream the 13-byte "hello world!\n" message with in_valid held high -> bytes emitted in order; frame period 41 cycles; lines_sent=1 after the "\n" stop bit completes; no byte duplicated or dropped.
- in_valid asserted and in_data toggled while busy -> no extra handshake; frame bits unchanged; next frame carries the in_data value present at the in_ready cycle.
- Wrap: send 256 bytes of 8'h0A -> lines_sent returns to 8'h00; 255 -> 8'hFF.
- UART_TX_PARITY_EN defined: 8'h68 -> parity bit 1; 8'h0A -> parity bit 0; frame length 44 cycles at CLKS_PER_BIT=4; STOP_BITS=2 adds 4 more high cycles.
